// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - opcode encodings, FSM states, lane enables and op-class helpers
package mem_access_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Big-endian lanes: bit 3 is byte offset 0 (data bits 31:24).
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b1000;
  localparam logic [3:0] BE_B1   = 4'b0100;
  localparam logic [3:0] BE_B2   = 4'b0010;
  localparam logic [3:0] BE_B3   = 4'b0001;
  localparam logic [3:0] BE_H0   = 4'b1100;
  localparam logic [3:0] BE_H1   = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return ~off[0];
      OP_LW, OP_SW:         return (off == 2'b00);
      default:              return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_lane_steer.sv
// rtl/mem_access_ctrl_store_lane_steer.sv - combinational big-endian store data/byte-enable steering
module store_lane_steer
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_din,
  output logic [3:0]  o_we
);

  always_comb begin
    o_din = i_wdata;
    o_we  = BE_NONE;
    case (i_opcode)
      OP_SB: begin
        o_din = {4{i_wdata[7:0]}};
        case (i_offset)
          2'd0:    o_we = BE_B0;
          2'd1:    o_we = BE_B1;
          2'd2:    o_we = BE_B2;
          default: o_we = BE_B3;
        endcase
      end
      OP_SH: begin
        o_din = {2{i_wdata[15:0]}};
        o_we  = i_offset[1] ? BE_H1 : BE_H0;
      end
      OP_SW:   o_we = BE_W;
      default: o_we = BE_NONE;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer onto a single-ported data cache
// Optional perf counters under MEM_ACCESS_CTRL_PERF_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [5:0]        req_opcode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              dcache_req_valid,
  input  logic              dcache_req_ready,
  output logic [ADDR_W-1:0] dcache_addr,
  output logic [3:0]        dcache_we,
  output logic [31:0]       dcache_din,
  input  logic              dcache_resp_valid,
  input  logic [31:0]       dcache_dout,
  output logic              wb_valid,
  output logic [5:0]        wb_opcode,
  output logic [1:0]        wb_byte_offset,
  output logic [31:0]       wb_data_raw,
  output logic              misalign,
  output logic              bus_error
`ifdef MEM_ACCESS_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_accesses
`endif
);

  state_t            r_state;
  logic [5:0]        r_opcode;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_din;
  logic [3:0]        r_we;
  logic [31:0]       r_data_raw;
  logic [7:0]        r_cnt;
  logic              r_req_valid;
  logic              r_wb_valid;
  logic              r_bus_error;

  logic [31:0] w_din;
  logic [3:0]  w_we;
  logic        w_mem_op;
  logic        w_aligned;
  logic        w_accept;

  store_lane_steer u_steer (
    .i_opcode (req_opcode),
    .i_offset (req_addr[1:0]),
    .i_wdata  (req_wdata),
    .o_din    (w_din),
    .o_we     (w_we)
  );

  assign w_mem_op  = is_load(req_opcode) | is_store(req_opcode);
  assign w_aligned = is_aligned(req_opcode, req_addr[1:0]);
  assign w_accept  = (r_state == ST_IDLE) && req_valid && w_mem_op && w_aligned;

  assign stall    = w_accept || (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign misalign = (r_state == ST_IDLE) && req_valid && w_mem_op && !w_aligned;

  assign dcache_req_valid = r_req_valid;
  assign dcache_addr      = {r_addr[ADDR_W-1:2], 2'b00};
  assign dcache_we        = r_we;
  assign dcache_din       = r_din;
  assign wb_valid         = r_wb_valid;
  assign wb_opcode        = r_opcode;
  assign wb_byte_offset   = r_addr[1:0];
  assign wb_data_raw      = r_data_raw;
  assign bus_error        = r_bus_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_opcode    <= '0;
      r_addr      <= '0;
      r_din       <= '0;
      r_we        <= '0;
      r_data_raw  <= '0;
      r_cnt       <= '0;
      r_req_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_bus_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opcode    <= req_opcode;
            r_addr      <= req_addr;
            r_din       <= w_din;
            r_we        <= w_we;
            r_data_raw  <= '0;
            r_req_valid <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dcache_req_ready) begin
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            if (is_store(r_opcode)) begin
              r_wb_valid <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // A response in the final allowed cycle beats the timeout.
          if (dcache_resp_valid) begin
            r_data_raw <= dcache_dout;
            r_wb_valid <= 1'b1;
            r_state    <= ST_DONE;
          end else if (r_cnt == 8'(WAIT_LIMIT - 1)) begin
            r_data_raw  <= '0;
            r_bus_error <= 1'b1;
            r_wb_valid  <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_acc   <= '0;
    end else begin
      if (stall)      r_perf_stall <= r_perf_stall + 32'd1;
      if (r_wb_valid) r_perf_acc   <= r_perf_acc + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_accesses     = r_perf_acc;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench with a behavioural cache and access model
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_opcode = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic        dcache_req_valid;
  logic        dcache_req_ready = 1'b0;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic        dcache_resp_valid = 1'b0;
  logic [31:0] dcache_dout = '0;
  logic        wb_valid;
  logic [5:0]  wb_opcode;
  logic [1:0]  wb_byte_offset;
  logic [31:0] wb_data_raw;
  logic        misalign;
  logic        bus_error;
`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_accesses;
`endif

  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_LIMIT(LIMIT), .ADDR_W(32)) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_opcode (req_opcode), .req_addr (req_addr), .req_wdata (req_wdata),
    .stall (stall),
    .dcache_req_valid (dcache_req_valid), .dcache_req_ready (dcache_req_ready),
    .dcache_addr (dcache_addr), .dcache_we (dcache_we), .dcache_din (dcache_din),
    .dcache_resp_valid (dcache_resp_valid), .dcache_dout (dcache_dout),
    .wb_valid (wb_valid), .wb_opcode (wb_opcode), .wb_byte_offset (wb_byte_offset),
    .wb_data_raw (wb_data_raw), .misalign (misalign), .bus_error (bus_error)
`ifdef MEM_ACCESS_CTRL_PERF_EN
    , .perf_stall_cycles (perf_stall_cycles), .perf_accesses (perf_accesses)
`endif
  );

  typedef struct {
    logic        mis;
    logic [5:0]  op;
    logic [1:0]  off;
    logic [31:0] data;
    logic        berr;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic        chk_din;
  } reqexp_t;

  exp_t    exp_q[$];
  reqexp_t req_q[$];
  int      errors = 0;
  int      checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic bit ref_is_load(input logic [5:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
  endfunction

  function automatic bit ref_is_mem(input logic [5:0] op);
    return ref_is_load(op) || op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic int ref_size(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_we(input logic [5:0] op, input logic [1:0] off);
    logic [3:0] we = '0;
    for (int i = 0; i < ref_size(op); i++) we[3 - (int'(off) + i)] = 1'b1;
    return we;
  endfunction

  // Every lane carries the byte that would land there for an access of this size.
  function automatic logic [31:0] ref_din(input logic [5:0] op, input logic [31:0] wd);
    logic [31:0] din = '0;
    logic [31:0] b;
    int sz = ref_size(op);
    for (int lane = 0; lane < 4; lane++) begin
      b = wd >> (8 * (sz - 1 - (lane % sz)));
      din[31 - 8 * lane -: 8] = b[7:0];
    end
    return din;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    dcache_req_ready  = 1'b0;
    dcache_resp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  // d: REQ cycles before ready; r: WAIT cycle (1-based) carrying the response.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int d, input int r, input logic [31:0] dout);
    exp_t    e;
    reqexp_t q;
    bit      ld;
    int      rc;
    int      wc;
    int      phase;
    bit      done;
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = addr;
    req_wdata  = wd;
    if (!ref_is_mem(op) || (addr % ref_size(op)) != 0) begin
      if (ref_is_mem(op)) begin
        e.mis = 1'b1; e.op = op; e.off = addr[1:0]; e.data = '0; e.berr = 1'b0; e.stalls = 0;
        exp_q.push_back(e);
      end
      if (wb_valid) tick();
      tick();
      if (!ref_is_mem(op)) tick();
      req_valid = 1'b0;
      return;
    end
    ld       = ref_is_load(op);
    e.mis    = 1'b0;
    e.op     = op;
    e.off    = addr[1:0];
    e.berr   = ld && (r > LIMIT);
    e.data   = (ld && r <= LIMIT) ? dout : 32'd0;
    e.stalls = 1 + (d + 1) + (ld ? ((r > LIMIT) ? LIMIT : r) : 0);
    exp_q.push_back(e);
    q.addr    = addr & ~32'd3;
    q.we      = ld ? 4'b0000 : ref_we(op, addr[1:0]);
    q.din     = ref_din(op, wd);
    q.chk_din = !ld;
    req_q.push_back(q);
    rc = 0; wc = 0; phase = 0; done = 0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      tick();
      if (phase == 1) begin
        wc++;
        if (wc == r) begin
          dcache_resp_valid = 1'b1;
          dcache_dout       = dout;
        end
      end
      if (phase == 0 && dcache_req_valid) begin
        if (rc == d) begin
          dcache_req_ready = 1'b1;
          phase = ld ? 1 : 2;
        end
        rc++;
      end
      if (wb_valid) begin
        done = 1;
        req_valid = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: got no wb_valid required one for op %0h", op);
      req_valid = 1'b0;
    end
  endtask

  exp_t    mon_e;
  reqexp_t mon_q;
  int      scnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      scnt = 0;
    end else begin
      if (stall) scnt++;
      if (dcache_req_valid) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 32'(dcache_req_valid), 32'd0);
        end else begin
          mon_q = req_q[0];
          check("req_addr", dcache_addr, mon_q.addr);
          check("req_we", 32'(dcache_we), 32'(mon_q.we));
          if (mon_q.chk_din) check("req_din", dcache_din, mon_q.din);
          if (dcache_req_ready) void'(req_q.pop_front());
        end
      end
      if (bus_error && !wb_valid) check("bus_error_without_wb", 32'(bus_error), 32'd0);
      if (misalign || wb_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, misalign, wb_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", 32'(misalign), 32'(mon_e.mis));
          if (mon_e.mis) begin
            check("misalign_stall", 32'(stall), 32'd0);
            check("misalign_prior_stalls", 32'(scnt), 32'd0);
          end else begin
            check("wb_opcode", 32'(wb_opcode), 32'(mon_e.op));
            check("wb_byte_offset", 32'(wb_byte_offset), 32'(mon_e.off));
            check("wb_data_raw", wb_data_raw, mon_e.data);
            check("bus_error", 32'(bus_error), 32'(mon_e.berr));
            check("stall_cycles", 32'(scnt), 32'(mon_e.stalls));
          end
        end
        scnt = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_req_valid"}, 32'(dcache_req_valid), 32'd0);
    check({tag, "_addr"}, dcache_addr, 32'd0);
    check({tag, "_we"}, 32'(dcache_we), 32'd0);
    check({tag, "_din"}, dcache_din, 32'd0);
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, "_wb_opcode"}, 32'(wb_opcode), 32'd0);
    check({tag, "_wb_off"}, 32'(wb_byte_offset), 32'd0);
    check({tag, "_wb_data"}, wb_data_raw, 32'd0);
    check({tag, "_misalign"}, 32'(misalign), 32'd0);
    check({tag, "_bus_error"}, 32'(bus_error), 32'd0);
  endtask

  logic [5:0] op_tab[10];

  initial begin
    op_tab = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'h0f, 6'h22};
    repeat (3) tick();
    rst = 1'b0;
    check_all_zero("reset");

    run_txn(OP_LB, 32'h103, 32'h0, 0, 1, 32'hAABBCC80);
    idle(1);
    run_txn(OP_SH, 32'h202, 32'h0000BEEF, 2, 1, 32'h0);
    idle(1);
    run_txn(OP_LW, 32'h101, 32'h0, 0, 1, 32'h0);
    idle(1);
    run_txn(OP_LW, 32'h300, 32'h0, 0, 99, 32'h12345678);
    run_txn(OP_LW, 32'h304, 32'h0, 1, LIMIT, 32'hCAFEF00D);
    run_txn(OP_LH, 32'h306, 32'h0, 0, LIMIT + 1, 32'hDEADBEEF);
    run_txn(6'h0f, 32'h400, 32'h0, 0, 1, 32'h0);
    idle(2);

    // Abandon a load in WAIT by reset, then let its response arrive late.
    begin
      reqexp_t q;
      q.addr = 32'h700; q.we = 4'b0000; q.din = '0; q.chk_din = 1'b0;
      req_q.push_back(q);
      req_valid = 1'b1; req_opcode = OP_LW; req_addr = 32'h700; req_wdata = '0;
      tick();
      dcache_req_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("midreset");
      dcache_resp_valid = 1'b1;
      dcache_dout = 32'h55AA55AA;
      tick();
      check_all_zero("stale_resp");
      idle(2);
    end

    run_txn(OP_SB, 32'h501, 32'h0000005A, 0, 1, 32'h0);
    run_txn(OP_LBU, 32'h602, 32'h0, 0, 1, 32'h11223344);
    idle(1);

    for (int i = 0; i < 150; i++) begin
      logic [5:0]  op;
      logic [31:0] addr;
      int          r;
      op   = op_tab[$urandom_range(0, 9)];
      addr = $urandom & 32'h0000_FFFF;
      r    = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(1, LIMIT + 1);
      run_txn(op, addr, $urandom, $urandom_range(0, 3), r, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
